// File: rtl/bin_to_bcd_seq_pkg.sv
// rtl/bin_to_bcd_seq_pkg.sv - shared constants and state encoding for the binary-to-BCD converter
package bin_to_bcd_seq_pkg;

    localparam int          BCD_DIGITS  = 4;
    localparam logic [15:0] BCD_MAX_DEC = 16'd9999;
    localparam logic [15:0] BCD_SAT     = 16'h9999;
    localparam logic [3:0]  ADJ_THRESH  = 4'd5;
    localparam logic [3:0]  ADJ_ADD     = 4'd3;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/bin_to_bcd_seq_digit_adj.sv
// rtl/bin_to_bcd_seq_digit_adj.sv - one BCD digit pre-shift correction: add 3 when the digit is 5 or more
module bcd_digit_adj
    import bin_to_bcd_seq_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // Wraps within 4 bits; a valid digit never exceeds 9, so no carry is lost.
    assign dout = (din >= ADJ_THRESH) ? din + ADJ_ADD : din;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - iterative shift-and-add-3 binary to 4-digit BCD converter with saturation
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int WIDTH = 14
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] BIN,
    output logic [15:0]      BCD,
    output logic             BUSY,
    output logic             DONE,
    output logic             OVF
);

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [15:0]        scr_q, scr_d;
    logic               sat_q, sat_d;
    logic [15:0]        bcd_q, bcd_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;

    logic [15:0]        adj;
    logic [15:0]        scr_shift;
    logic [15:0]        bin_ext;

    genvar g;
    generate
        for (g = 0; g < BCD_DIGITS; g++) begin : g_adj
            bcd_digit_adj u_adj (
                .din  (scr_q[4*g +: 4]),
                .dout (adj[4*g +: 4])
            );
        end
    endgenerate

    assign bin_ext   = {{(16-WIDTH){1'b0}}, BIN};
    assign scr_shift = {adj[14:0], shreg_q[WIDTH-1]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        scr_d   = scr_q;
        sat_d   = sat_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (START) begin
                    shreg_d = BIN;
                    scr_d   = 16'h0000;
                    cnt_d   = 4'(WIDTH);
                    sat_d   = (bin_ext > BCD_MAX_DEC);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                scr_d   = scr_shift;
                shreg_d = shreg_q << 1;
                cnt_d   = cnt_q - 4'd1;
                // Final shift: publish the result; display register is untouched until now.
                if (cnt_q == 4'd1) begin
                    bcd_d   = sat_q ? BCD_SAT : scr_shift;
                    ovf_d   = sat_q;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            shreg_q <= '0;
            scr_q   <= 16'h0000;
            sat_q   <= 1'b0;
            bcd_q   <= 16'h0000;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            scr_q   <= scr_d;
            sat_q   <= sat_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign BCD  = bcd_q;
    assign BUSY = (state_q == SHIFT);
    assign DONE = done_q;
    assign OVF  = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - directed and swept self-checking bench for bin_to_bcd_seq
module tb_bin_to_bcd_seq;

    logic        CLK;
    logic        RST;
    logic        START;
    logic [13:0] BIN;
    logic [15:0] BCD;
    logic        BUSY;
    logic        DONE;
    logic        OVF;

    int checks;
    int errors;

    bin_to_bcd_seq #(.WIDTH(14)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .BIN   (BIN),
        .BCD   (BCD),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .OVF   (OVF)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_bcd(input int v);
        if (v > 9999) return 16'h9999;
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Single START pulse; checks latency, hold of old result, BUSY, result and OVF.
    task automatic convert(input string tag, input int v, input logic [15:0] exp_bcd, input logic exp_ovf);
        logic [15:0] old;
        int          k;
        logic        held;
        logic        busy_ok;
        @(negedge CLK);
        BIN   = 14'(v);
        START = 1'b1;
        old   = BCD;
        @(negedge CLK);
        START   = 1'b0;
        BIN     = 14'($urandom_range(0, 16383));
        k       = 0;
        held    = 1'b1;
        busy_ok = 1'b1;
        while (!DONE && k < 40) begin
            if (BCD !== old) held = 1'b0;
            if (BUSY !== 1'b1) busy_ok = 1'b0;
            @(negedge CLK);
            k++;
        end
        check({tag, "_lat"}, k, 14);
        check({tag, "_hold"}, held, 1);
        check({tag, "_busy"}, busy_ok, 1);
        check({tag, "_bcd"}, BCD, exp_bcd);
        check({tag, "_ovf"}, OVF, exp_ovf);
        check({tag, "_busy_done"}, BUSY, 0);
        @(negedge CLK);
        check({tag, "_done_pulse"}, DONE, 0);
    endtask

    initial begin
        logic seen_done;
        int   d1, d2;
        logic [15:0] b1, b2;
        int   v;
        checks = 0;
        errors = 0;
        RST    = 1'b1;
        START  = 1'b0;
        BIN    = '0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;

        seen_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (DONE) seen_done = 1'b1;
        end
        check("rst_bcd", BCD, 16'h0000);
        check("rst_busy", BUSY, 0);
        check("rst_ovf", OVF, 0);
        check("idle_no_done", seen_done, 0);

        convert("c1234", 1234, 16'h1234, 1'b0);
        convert("c0", 0, 16'h0000, 1'b0);
        convert("c9999", 9999, 16'h9999, 1'b0);
        convert("c10000", 10000, 16'h9999, 1'b1);
        convert("c16383", 16383, 16'h9999, 1'b1);
        convert("c42", 42, 16'h0042, 1'b0);

        // START held high: second conversion must be taken in the DONE cycle.
        @(negedge CLK);
        START = 1'b1;
        BIN   = 14'd57;
        d1 = -1; d2 = -1; b1 = '0; b2 = '0;
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
            if (i == 4) BIN = 14'd300;
            if (DONE) begin
                if (d1 < 0) begin d1 = i; b1 = BCD; end
                else if (d2 < 0) begin d2 = i; b2 = BCD; end
            end
        end
        START = 1'b0;
        check("b2b_first_at", d1, 14);
        check("b2b_first_bcd", b1, 16'h0057);
        check("b2b_second_at", d2, 29);
        check("b2b_second_bcd", b2, 16'h0300);
        repeat (16) @(negedge CLK);
        check("b2b_idle", BUSY, 0);

        convert("pre_rst", 1234, 16'h1234, 1'b0);
        @(negedge CLK);
        BIN   = 14'd8765;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (5) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("midrst_bcd", BCD, 16'h0000);
        check("midrst_busy", BUSY, 0);
        check("midrst_done", DONE, 0);
        seen_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (DONE) seen_done = 1'b1;
        end
        check("midrst_no_done", seen_done, 0);
        convert("post_rst", 8765, 16'h8765, 1'b0);

        for (int i = 0; i < 24; i++) begin
            v = (i < 4) ? (i == 0 ? 9998 : i == 1 ? 10001 : i == 2 ? 1 : 905)
                        : int'($urandom_range(0, 16383));
            convert($sformatf("sweep%0d_%0d", i, v), v, ref_bcd(v), v > 9999);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
